alu_issue_stage: RTL

Operand/command issue stage directly upstream of the 32-bit ALU (ALU32bit: result, control, zero, carryout, overflow, a, b). Buffers ALU commands from the decode side in a small FIFO and drives the ALU's control and operand inputs from the FIFO head. Captures the ALU's combinational result and flags into an output register with a valid/ready handshake toward writeback. Also keeps a sticky overflow status bit.

---
 rtl/alu_issue_stage.sv | 138 +++++++++++++
 1 files changed

// File: rtl/alu_issue_stage.sv
// Issue stage feeding a 32-bit combinational ALU: command FIFO drives the ALU from
// its head, and an output register captures the result and flags toward writeback.
module alu_issue_stage #(
  parameter int DEPTH = 4,
  parameter int TAGW  = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [2:0]               in_op,
  input  logic [31:0]              in_a,
  input  logic [31:0]              in_b,
  input  logic [TAGW-1:0]          in_tag,
  output logic [2:0]               alu_control,
  output logic [31:0]              alu_a,
  output logic [31:0]              alu_b,
  input  logic [31:0]              alu_result,
  input  logic                     alu_zero,
  input  logic                     alu_carryout,
  input  logic                     alu_overflow,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [31:0]              out_result,
  output logic                     out_zero,
  output logic                     out_carryout,
  output logic                     out_overflow,
  output logic [TAGW-1:0]          out_tag,
  output logic                     sticky_ovf,
  input  logic                     clear_sticky,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW     = $clog2(DEPTH);
  localparam int DATA_W = 32;
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  typedef struct packed {
    logic [2:0]        op;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic [TAGW-1:0]   tag;
  } cmd_t;

  // Carry and overflow only carry meaning for ADD and SUB.
  function automatic logic is_arith(input logic [2:0] op);
    return (op == 3'd0) || (op == 3'd1);
  endfunction

  cmd_t            mem [DEPTH];
  cmd_t            head_p0;
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [AW:0]     cnt;
  logic            empty;
  logic            full;
  logic            push;
  logic            pop;
  logic            arith_p0;

  logic              vld_p1;
  logic [DATA_W-1:0] result_p1;
  logic              zero_p1;
  logic              carry_p1;
  logic              ovf_p1;
  logic [TAGW-1:0]   tag_p1;
  logic              sticky_p1;

  assign empty    = (cnt == '0);
  assign full     = (cnt == FULL_CNT);
  assign in_ready = !full;
  assign push     = in_valid && !full;
  assign pop      = !empty && (!vld_p1 || out_ready);
  assign head_p0  = mem[rd_ptr];
  assign arith_p0 = is_arith(alu_control);

  assign alu_control = empty ? 3'd0 : head_p0.op;
  assign alu_a       = empty ? '0 : head_p0.a;
  assign alu_b       = empty ? '0 : head_p0.b;

  // Stage p0: FIFO storage and control
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= '{op: in_op, a: in_a, b: in_b, tag: in_tag};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  // Stage p1: result register toward writeback
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1    <= 1'b0;
      result_p1 <= '0;
      zero_p1   <= 1'b0;
      carry_p1  <= 1'b0;
      ovf_p1    <= 1'b0;
      tag_p1    <= '0;
      sticky_p1 <= 1'b0;
    end else begin
      if (pop) begin
        vld_p1    <= 1'b1;
        result_p1 <= alu_result;
        zero_p1   <= alu_zero;
        carry_p1  <= arith_p0 && alu_carryout;
        ovf_p1    <= arith_p0 && alu_overflow;
        tag_p1    <= head_p0.tag;
      end else if (out_ready) begin
        vld_p1 <= 1'b0;
      end
      // A new overflow outranks a coincident clear.
      if (pop && arith_p0 && alu_overflow) sticky_p1 <= 1'b1;
      else if (clear_sticky)               sticky_p1 <= 1'b0;
    end
  end

  assign out_valid    = vld_p1;
  assign out_result   = result_p1;
  assign out_zero     = zero_p1;
  assign out_carryout = carry_p1;
  assign out_overflow = ovf_p1;
  assign out_tag      = tag_p1;
  assign sticky_ovf   = sticky_p1;
  assign count        = cnt;

endmodule
